// File: rtl/approx_seq_multiplier.sv
// rtl/approx_seq_multiplier.sv - iterative shift-and-add multiplier with approximate low accumulator columns
// One partial product per cycle; the low APPROX_BITS columns of the accumulator adder are carry-free OR cells.

module approx_seq_multiplier_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_x ^ i_y ^ i_cin;
  assign o_cout = (i_x & i_y) | (i_cin & (i_x ^ i_y));
endmodule

module approx_seq_multiplier_add #(
  parameter int N      = 16,
  parameter int APPROX = 4
) (
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N-1:0] o_sum
);
  // The first exact column sees a zero carry-in; the carry out of the top column is dropped.
  for (genvar j = 0; j < N; j++) begin : g_col
    if (j < APPROX) begin : g_or
      assign o_sum[j] = i_x[j] | i_y[j];
    end else if (j == N - 1) begin : g_top
      logic w_cin;
      if (j == APPROX) begin : g_c0
        assign w_cin = 1'b0;
      end else begin : g_cr
        assign w_cin = g_col[j-1].g_fa.w_cout;
      end
      assign o_sum[j] = i_x[j] ^ i_y[j] ^ w_cin;
    end else begin : g_fa
      logic w_cin;
      logic w_cout;
      if (j == APPROX) begin : g_c0
        assign w_cin = 1'b0;
      end else begin : g_cr
        assign w_cin = g_col[j-1].g_fa.w_cout;
      end
      approx_seq_multiplier_fa u_fa (
        .i_x   (i_x[j]),
        .i_y   (i_y[j]),
        .i_cin (w_cin),
        .o_sum (o_sum[j]),
        .o_cout(w_cout)
      );
    end
  end
endmodule

module approx_seq_multiplier #(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_mcand;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_product;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   w_addend;
  logic [PW-1:0]   w_sum;
  logic [PW-1:0]   w_acc_next;
  logic            w_accept;
  logic            w_last;

  assign w_addend   = r_mcand << r_cnt;
  assign w_acc_next = r_mplier[r_cnt] ? w_sum : r_acc;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  approx_seq_multiplier_add #(
    .N     (PW),
    .APPROX(APPROX_BITS)
  ) u_add (
    .i_x  (r_acc),
    .i_y  (w_addend),
    .o_sum(w_sum)
  );

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        w_accept = in_valid && !rst;
        if (w_accept) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = !rst;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          // product only changes on the RUN->DONE step and holds otherwise
          if (w_last) r_product <= w_acc_next;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
endmodule
